trap_sequencer: RTL and testbench

Sequences control-flow redirection for traps and trap returns in the RV32I pipeline. It sits between the CSR/exception-handling unit and fetch. On an exception it flushes the FD and XB stages, holds the pipeline, hands the trap vector to fetch with a valid/ready handshake, and waits a programmable settle time. It does the same for MRET, using the saved exception PC as the target.

---
 rtl/trap_sequencer.sv | 183 ++++++++++++++++++
 tb/tb_trap_sequencer.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/trap_sequencer.sv
// Trap/MRET redirect sequencer: flushes FD/XB, stalls, hands the target PC to fetch, then settles.
// Latency: event sampled at edge N -> flush in N+1, redirect_valid from N+2, release SETTLE_CYCLES after transfer.
// Backpressure: redirect_valid/redirect_pc held stable until fetch_ready; stall held throughout a sequence.
// Optional: define TRAP_SEQ_WDOG_EN to add the redirect handshake watchdog and the wdog_timeout port.
module trap_sequencer #(
  parameter int unsigned SETTLE_CYCLES = 1,
  parameter int unsigned WDOG_CYCLES   = 64
) (
  input  logic        clk,
  input  logic        resetb,
  input  logic        initiate_exception,
  input  logic        mret,
  input  logic [31:0] csr_mtvec,
  input  logic [31:0] csr_mepc,
  input  logic        fetch_ready,
  output logic        flush_fd,
  output logic        flush_xb,
  output logic        stall,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
`ifdef TRAP_SEQ_WDOG_EN
  output logic        wdog_timeout,
`endif
  output logic        in_trap
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FLUSH    = 2'd1,
    REDIRECT = 2'd2,
    SETTLE   = 2'd3
  } state_e;

  // Settle counter counts down to zero, so it starts one below the cycle count.
  localparam logic [3:0] SETTLE_LOAD = (SETTLE_CYCLES == 0) ? 4'd0 : 4'(SETTLE_CYCLES - 1);

  state_e      state_q, state_d;
  logic        pending_exc_q, pending_exc_d;
  logic        in_trap_q, in_trap_d;
  logic [31:0] target_q, target_d;
  logic [3:0]  settle_cnt_q, settle_cnt_d;
  logic        wdog_expire;

  // Targets are forced word aligned, so the CSR low bits never matter here.
  logic        csr_low_bits_unused;
  assign csr_low_bits_unused = ^{csr_mtvec[1:0], csr_mepc[1:0]};

`ifdef TRAP_SEQ_WDOG_EN
  localparam int unsigned       WDOG_W    = (WDOG_CYCLES > 1) ? $clog2(WDOG_CYCLES) : 1;
  localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(WDOG_CYCLES - 1);

  logic [WDOG_W-1:0] wdog_cnt_q, wdog_cnt_d;
  logic              wdog_flag_q, wdog_flag_d;

  // Expires at the end of the WDOG_CYCLES-th cycle spent waiting in REDIRECT.
  assign wdog_expire  = (wdog_cnt_q == WDOG_LAST);
  assign wdog_timeout = wdog_flag_q;
`else
  logic wdog_cfg_unused;
  assign wdog_cfg_unused = (WDOG_CYCLES != 0);
  assign wdog_expire     = 1'b0;
`endif

  assign redirect_pc = target_q;
  assign in_trap     = in_trap_q;

  // Next-state, target/pending bookkeeping and per-state outputs.
  always_comb begin
    state_d        = state_q;
    pending_exc_d  = pending_exc_q;
    in_trap_d      = in_trap_q;
    target_d       = target_q;
    settle_cnt_d   = settle_cnt_q;
    flush_fd       = 1'b0;
    flush_xb       = 1'b0;
    stall          = 1'b0;
    redirect_valid = 1'b0;
`ifdef TRAP_SEQ_WDOG_EN
    wdog_cnt_d     = wdog_cnt_q;
    wdog_flag_d    = wdog_flag_q;
`endif

    case (state_q)
      IDLE: begin
        // Exceptions (fresh or deferred) outrank MRET; a simultaneous MRET is dropped.
        if (pending_exc_q || initiate_exception) begin
          state_d       = FLUSH;
          target_d      = {csr_mtvec[31:2], 2'b00};
          in_trap_d     = 1'b1;
          pending_exc_d = 1'b0;
        end else if (mret) begin
          state_d       = FLUSH;
          target_d      = {csr_mepc[31:2], 2'b00};
          in_trap_d     = 1'b0;
          pending_exc_d = 1'b0;
        end
      end

      FLUSH: begin
        flush_fd = 1'b1;
        flush_xb = 1'b1;
        stall    = 1'b1;
        state_d  = REDIRECT;
`ifdef TRAP_SEQ_WDOG_EN
        wdog_cnt_d = '0;
`endif
      end

      REDIRECT: begin
        redirect_valid = 1'b1;
        stall          = 1'b1;
        // A watchdog expiry is treated exactly like a completed transfer.
        if (fetch_ready || wdog_expire) begin
`ifdef TRAP_SEQ_WDOG_EN
          if (!fetch_ready) begin
            wdog_flag_d = 1'b1;
          end
`endif
          if (SETTLE_CYCLES == 0) begin
            state_d = IDLE;
          end else begin
            state_d      = SETTLE;
            settle_cnt_d = SETTLE_LOAD;
          end
        end
`ifdef TRAP_SEQ_WDOG_EN
        else begin
          wdog_cnt_d = wdog_cnt_q + 1'b1;
        end
`endif
      end

      SETTLE: begin
        stall = 1'b1;
        if (settle_cnt_q == 4'd0) begin
          state_d = IDLE;
        end else begin
          settle_cnt_d = settle_cnt_q - 4'd1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // A trap arriving mid-sequence is remembered once; MRET mid-sequence is being squashed.
    if ((state_q != IDLE) && initiate_exception) begin
      pending_exc_d = 1'b1;
    end
  end

  // State and bookkeeping registers; reset abandons any in-flight sequence.
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      state_q       <= IDLE;
      pending_exc_q <= 1'b0;
      in_trap_q     <= 1'b0;
      target_q      <= 32'd0;
      settle_cnt_q  <= 4'd0;
    end else begin
      state_q       <= state_d;
      pending_exc_q <= pending_exc_d;
      in_trap_q     <= in_trap_d;
      target_q      <= target_d;
      settle_cnt_q  <= settle_cnt_d;
    end
  end

`ifdef TRAP_SEQ_WDOG_EN
  // Watchdog cycle counter and sticky timeout flag.
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      wdog_cnt_q  <= '0;
      wdog_flag_q <= 1'b0;
    end else begin
      wdog_cnt_q  <= wdog_cnt_d;
      wdog_flag_q <= wdog_flag_d;
    end
  end
`endif

endmodule

// File: tb/tb_trap_sequencer.sv
// Bench for trap_sequencer: directed scenarios with literal expectations plus randomized traffic.
// A transaction-level model predicts outputs; one compare process checks them every cycle.
// Watchdog scenarios are included when TRAP_SEQ_WDOG_EN is defined.
module tb_trap_sequencer;

  localparam int unsigned SETTLE = 1;
  localparam int unsigned WDOG   = 8;
`ifdef TRAP_SEQ_WDOG_EN
  localparam bit WDOG_ON = 1'b1;
`else
  localparam bit WDOG_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        resetb = 1'b0;
  logic        initiate_exception = 1'b0;
  logic        mret = 1'b0;
  logic        fetch_ready = 1'b0;
  logic [31:0] csr_mtvec = 32'd0;
  logic [31:0] csr_mepc = 32'd0;
  logic        flush_fd, flush_xb, stall, redirect_valid, in_trap;
  logic [31:0] redirect_pc;
  logic        wdog_timeout;

  trap_sequencer #(.SETTLE_CYCLES(SETTLE), .WDOG_CYCLES(WDOG)) dut (
    .clk                (clk),
    .resetb             (resetb),
    .initiate_exception (initiate_exception),
    .mret               (mret),
    .csr_mtvec          (csr_mtvec),
    .csr_mepc           (csr_mepc),
    .fetch_ready        (fetch_ready),
    .flush_fd           (flush_fd),
    .flush_xb           (flush_xb),
    .stall              (stall),
    .redirect_valid     (redirect_valid),
    .redirect_pc        (redirect_pc),
`ifdef TRAP_SEQ_WDOG_EN
    .wdog_timeout       (wdog_timeout),
`endif
    .in_trap            (in_trap)
  );

`ifndef TRAP_SEQ_WDOG_EN
  assign wdog_timeout = 1'b0;
`endif

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // A sequence is: one flush cycle, redirect cycles until accepted, then SETTLE quiet-stall cycles.
  bit          m_busy = 0;
  bit          m_flush = 0;
  bit          m_xfer = 0;
  bit          m_pend = 0;
  bit          m_trap = 0;
  bit          m_wdog = 0;
  int          m_settle = 0;
  int          m_rwait = 0;
  logic [31:0] m_tgt = 32'd0;

  always @(posedge clk or negedge resetb) begin
    bit done;
    if (!resetb) begin
      m_busy = 0; m_flush = 0; m_xfer = 0; m_pend = 0; m_trap = 0;
      m_wdog = 0; m_settle = 0; m_rwait = 0; m_tgt = 32'd0;
    end else if (!m_busy) begin
      if (m_pend || initiate_exception) begin
        m_busy = 1; m_flush = 1; m_xfer = 0; m_rwait = 0; m_pend = 0;
        m_tgt = csr_mtvec & 32'hFFFF_FFFC;
        m_trap = 1;
      end else if (mret) begin
        m_busy = 1; m_flush = 1; m_xfer = 0; m_rwait = 0; m_pend = 0;
        m_tgt = csr_mepc & 32'hFFFF_FFFC;
        m_trap = 0;
      end
    end else begin
      if (initiate_exception) m_pend = 1;
      if (m_flush) begin
        m_flush = 0;
      end else if (!m_xfer) begin
        done = fetch_ready;
        if (!done) begin
          m_rwait++;
          if (WDOG_ON && m_rwait == WDOG) begin
            done = 1;
            m_wdog = 1;
          end
        end
        if (done) begin
          m_xfer = 1;
          m_settle = SETTLE;
          if (m_settle == 0) m_busy = 0;
        end
      end else begin
        m_settle--;
        if (m_settle == 0) m_busy = 0;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    logic e_flush, e_rv;
    e_flush = m_busy && m_flush;
    e_rv    = m_busy && !m_flush && !m_xfer;
    check("cycle_model",
          {26'd0, flush_fd, flush_xb, stall, redirect_valid, in_trap, wdog_timeout, redirect_pc},
          {26'd0, e_flush, e_flush, m_busy, e_rv, m_trap, m_wdog, m_tgt});
  end

  // Waits (bounded) until the sequencer is idle; leaves the caller at the first idle negedge.
  task automatic wait_idle(input string name);
    int n = 0;
    @(negedge clk);
    while (stall !== 1'b0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check(name, {63'd0, stall}, 64'd0);
  endtask

  // Pulses an event for one sampling edge; returns just after edge N.
  task automatic pulse(input bit exc, input bit ret);
    @(posedge clk); #1;
    initiate_exception = exc;
    mret = ret;
    @(posedge clk); #1;
    initiate_exception = 1'b0;
    mret = 1'b0;
  endtask

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1 resetb = 1'b1;
    @(negedge clk);
    check("reset_outputs",
          {26'd0, flush_fd, flush_xb, stall, redirect_valid, in_trap, wdog_timeout, redirect_pc}, 64'd0);

    // Basic trap
    csr_mtvec = 32'h0000_0105; fetch_ready = 1'b1;
    pulse(1'b1, 1'b0);
    @(negedge clk); check("basic_flush", {flush_fd, flush_xb, stall, redirect_valid}, 4'b1110);
    @(negedge clk); check("basic_redirect", {flush_fd, flush_xb, stall, redirect_valid, redirect_pc},
                          {4'b0011, 32'h0000_0104});
    @(negedge clk); check("basic_settle", {stall, redirect_valid}, 2'b10);
    @(negedge clk); check("basic_release", {stall, in_trap}, 2'b01);

    // MRET with stalled fetch
    csr_mepc = 32'h0000_2008; fetch_ready = 1'b0;
    pulse(1'b0, 1'b1);
    @(negedge clk); check("mret_flush", {flush_fd, stall, in_trap}, 3'b110);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("mret_hold", {redirect_valid, redirect_pc}, {1'b1, 32'h0000_2008});
      if (i == 1) mret = 1'b1;
      if (i == 2) mret = 1'b0;
      if (i == 5) fetch_ready = 1'b1;
    end
    @(negedge clk); check("mret_done", {redirect_valid, stall, in_trap}, 3'b010);
    wait_idle("mret_idle");

    // Simultaneous exception and mret
    csr_mtvec = 32'h3000_0007; csr_mepc = 32'h0000_4444;
    pulse(1'b1, 1'b1);
    @(negedge clk);
    @(negedge clk); check("simul_target", {redirect_valid, in_trap, redirect_pc}, {2'b11, 32'h3000_0004});
    wait_idle("simul_idle");
    repeat (4) begin
      @(negedge clk); check("simul_single", {stall, flush_fd}, 2'b00);
    end

    // Pending collapse
    csr_mtvec = 32'h0000_0200; fetch_ready = 1'b0;
    pulse(1'b1, 1'b0);
    @(negedge clk);
    @(negedge clk); check("pend_in_redirect", {63'd0, redirect_valid}, 64'd1);
    initiate_exception = 1'b1;
    @(negedge clk); initiate_exception = 1'b0;
    @(negedge clk); initiate_exception = 1'b1;
    @(negedge clk); initiate_exception = 1'b0; fetch_ready = 1'b1;
    wait_idle("pend_first_idle");
    @(negedge clk); check("pend_second_start", {flush_fd, stall}, 2'b11);
    wait_idle("pend_second_idle");
    repeat (5) begin
      @(negedge clk); check("pend_no_third", {stall, flush_fd}, 2'b00);
    end

    // Reset mid-REDIRECT with a pending exception
    fetch_ready = 1'b0;
    pulse(1'b1, 1'b0);
    @(negedge clk);
    @(negedge clk); initiate_exception = 1'b1;
    @(negedge clk); initiate_exception = 1'b0;
    check("pre_reset_redirect", {63'd0, redirect_valid}, 64'd1);
    #2 resetb = 1'b0;
    #1 check("reset_async",
             {26'd0, flush_fd, flush_xb, stall, redirect_valid, in_trap, wdog_timeout, redirect_pc}, 64'd0);
    @(negedge clk);
    @(negedge clk);
    #2 resetb = 1'b1; fetch_ready = 1'b1;
    repeat (6) begin
      @(negedge clk); check("reset_no_redirect", {stall, redirect_valid, flush_fd}, 3'b000);
    end

`ifdef TRAP_SEQ_WDOG_EN
    // Watchdog
    csr_mtvec = 32'h0000_0800; fetch_ready = 1'b0;
    pulse(1'b1, 1'b0);
    @(negedge clk);
    for (int i = 0; i < int'(WDOG); i++) begin
      @(negedge clk); check("wdog_wait", {redirect_valid, wdog_timeout}, 2'b10);
    end
    @(negedge clk); check("wdog_fire", {redirect_valid, stall, wdog_timeout}, 3'b011);
    wait_idle("wdog_idle");
    repeat (3) begin
      @(negedge clk); check("wdog_sticky", {63'd0, wdog_timeout}, 64'd1);
    end
`endif

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      initiate_exception = ($urandom_range(0, 7) == 0);
      mret               = ($urandom_range(0, 5) == 0);
      fetch_ready        = (c % 1000 < 500) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 5) == 0);
      csr_mtvec          = $urandom;
      csr_mepc           = $urandom;
      if ($urandom_range(0, 499) == 0) begin
        resetb = 1'b0;
        #2 resetb = 1'b1;
      end
    end
    @(posedge clk); #1;
    initiate_exception = 1'b0; mret = 1'b0; fetch_ready = 1'b1;
    repeat (20) @(posedge clk);
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
